// File: rtl/fp_operand_deserializer.sv
// Byte-serial front end for the FP ALU core: gathers operand A, then operand B,
// one byte per accepted beat, and offers {op_a, op_b, opcode} on a valid/ready handshake.
module fp_operand_deserializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 255,
  parameter int TW        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic [1:0]  opcode_in,
  input  logic        start,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  opcode,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        busy,
  output logic [3:0]  state,
  output logic        err
);

  // Handshake: a transfer happens on a rising edge where op_valid && op_ready;
  // once op_valid rises it and the operand/opcode outputs stay put until that transfer.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [1:0]      opcode_q, opcode_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            err_q, err_d;

  function automatic logic [31:0] shift_byte(input logic [31:0] cur, input logic [7:0] b);
    if (MSB_FIRST) return {cur[23:0], b};
    else           return {b, cur[31:8]};
  endfunction

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opcode_d = opcode_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d = opcode_in;
          bcnt_d   = 2'd0;
          tcnt_d   = '0;
          state_d  = LOAD_A;
        end
      end
      LOAD_A, LOAD_B: begin
        // A restart outranks any byte presented in the same cycle.
        if (start) begin
          err_d    = 1'b1;
          opcode_d = opcode_in;
          bcnt_d   = 2'd0;
          tcnt_d   = '0;
          state_d  = LOAD_A;
        end else if (in_valid) begin
          bcnt_d = bcnt_q + 2'd1;
          tcnt_d = '0;
          if (state_q == LOAD_A) op_a_d = shift_byte(op_a_q, in_byte);
          else                   op_b_d = shift_byte(op_b_q, in_byte);
          if (bcnt_q == 2'd3) state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
        end else if (TIMEOUT != 0) begin
          if (tcnt_q == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            bcnt_d  = 2'd0;
            tcnt_d  = '0;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ISSUE: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign opcode   = opcode_q;
  assign op_valid = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign state    = {2'b00, state_q};
  assign err      = err_q;

endmodule

// File: tb/tb_fp_operand_deserializer.sv
// Directed bench: big-endian default instance, little-endian instance with a
// short timeout, and a timeout-disabled instance, all sharing one input bus.
module tb_fp_operand_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [1:0]  opcode_in;
  logic        start;
  logic        op_ready;

  logic [31:0] b_op_a, b_op_b, l_op_a, l_op_b, n_op_a, n_op_b;
  logic [1:0]  b_opcode, l_opcode, n_opcode;
  logic        b_op_valid, l_op_valid, n_op_valid;
  logic        b_busy, l_busy, n_busy;
  logic [3:0]  b_state, l_state, n_state;
  logic        b_err, l_err, n_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] basic_bytes [0:7] = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
  logic [7:0] le_bytes    [0:7] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'hC0};
  logic [7:0] rs_bytes    [0:7] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  always #5 clk = ~clk;

  fp_operand_deserializer u_be (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .opcode_in(opcode_in),
    .start(start), .op_a(b_op_a), .op_b(b_op_b), .opcode(b_opcode), .op_valid(b_op_valid),
    .op_ready(op_ready), .busy(b_busy), .state(b_state), .err(b_err));

  fp_operand_deserializer #(.MSB_FIRST(1'b0), .TIMEOUT(4), .TW(8)) u_le (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .opcode_in(opcode_in),
    .start(start), .op_a(l_op_a), .op_b(l_op_b), .opcode(l_opcode), .op_valid(l_op_valid),
    .op_ready(op_ready), .busy(l_busy), .state(l_state), .err(l_err));

  fp_operand_deserializer #(.MSB_FIRST(1'b1), .TIMEOUT(0), .TW(8)) u_nt (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .opcode_in(opcode_in),
    .start(start), .op_a(n_op_a), .op_b(n_op_b), .opcode(n_opcode), .op_valid(n_op_valid),
    .op_ready(op_ready), .busy(n_busy), .state(n_state), .err(n_err));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; opcode_in = 2'b00; op_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (b_state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", b_state); end
    n_cmp++; if (b_op_a !== 32'h0 || b_op_b !== 32'h0) begin n_fail++; $display("FAIL reset_ops got=%h/%h exp=0/0", b_op_a, b_op_b); end
    n_cmp++; if ({b_opcode, b_op_valid, b_busy, b_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {b_opcode, b_op_valid, b_busy, b_err}); end
    n_cmp++; if ({l_state, l_op_valid, l_busy, l_err} !== 7'b0) begin n_fail++; $display("FAIL reset_le got=%b exp=0000000", {l_state, l_op_valid, l_busy, l_err}); end
  endtask

  task automatic test_basic();
    int vcount;
    logic [3:0] exp_st;
    apply_reset();
    op_ready = 1'b1; opcode_in = 2'b01; start = 1'b1; in_valid = 1'b1; in_byte = 8'hAA;
    step();
    start = 1'b0;
    n_cmp++; if (b_state !== 4'd1) begin n_fail++; $display("FAIL basic_start_state got=%0d exp=1", b_state); end
    n_cmp++; if (b_op_a !== 32'h0) begin n_fail++; $display("FAIL basic_idle_byte_ignored got=%h exp=0", b_op_a); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = basic_bytes[i];
      step();
      exp_st = (i < 3) ? 4'd1 : (i < 7) ? 4'd2 : 4'd3;
      n_cmp++; if (b_state !== exp_st) begin n_fail++; $display("FAIL basic_state byte%0d got=%0d exp=%0d", i, b_state, exp_st); end
    end
    in_valid = 1'b0;
    n_cmp++; if (b_op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", b_op_valid); end
    n_cmp++; if (b_op_a !== 32'h3F800000) begin n_fail++; $display("FAIL basic_op_a got=%h exp=3f800000", b_op_a); end
    n_cmp++; if (b_op_b !== 32'h40000000) begin n_fail++; $display("FAIL basic_op_b got=%h exp=40000000", b_op_b); end
    n_cmp++; if (b_opcode !== 2'b01) begin n_fail++; $display("FAIL basic_opcode got=%b exp=01", b_opcode); end
    vcount = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (b_op_valid === 1'b1) vcount++;
      if (k == 0) begin
        n_cmp++; if (b_state !== 4'd0) begin n_fail++; $display("FAIL basic_end_state got=%0d exp=0", b_state); end
      end
    end
    n_cmp++; if (vcount !== 1) begin n_fail++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcount); end
  endtask

  task automatic test_back_to_back();
    op_ready = 1'b1; opcode_in = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (b_state !== 4'd1) begin n_fail++; $display("FAIL b2b_start got=%0d exp=1", b_state); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = rs_bytes[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (b_op_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", b_op_valid); end
    n_cmp++; if ({b_op_a, b_op_b, b_opcode} !== {32'h12345678, 32'h9ABCDEF0, 2'b10}) begin n_fail++; $display("FAIL b2b_data got=%h %h %b exp=12345678 9abcdef0 10", b_op_a, b_op_b, b_opcode); end
    // Start presented the very cycle IDLE is re-entered.
    step();
    n_cmp++; if (b_state !== 4'd0) begin n_fail++; $display("FAIL b2b_idle got=%0d exp=0", b_state); end
    opcode_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (b_state !== 4'd1 || b_opcode !== 2'b11) begin n_fail++; $display("FAIL b2b_restart_idle got=%0d/%b exp=1/11", b_state, b_opcode); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    op_ready = 1'b0; opcode_in = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = basic_bytes[i];
      step();
      in_valid = 1'b0;
      if (i < 7) begin
        step();
        n_cmp++; if (b_op_valid !== 1'b0) begin n_fail++; $display("FAIL bp_early_valid byte%0d got=%b exp=0", i, b_op_valid); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (b_op_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle%0d got=%b exp=1", k, b_op_valid); end
      n_cmp++; if ({b_op_a, b_op_b, b_opcode} !== {32'h3F800000, 32'h40000000, 2'b01}) begin n_fail++; $display("FAIL bp_hold cycle%0d got=%h %h %b exp=3f800000 40000000 01", k, b_op_a, b_op_b, b_opcode); end
      if (k < 5) begin
        start = k[0]; in_valid = 1'b1; in_byte = 8'hF0 + 8'(k); opcode_in = 2'b10; op_ready = 1'b0;
      end else begin
        start = 1'b0; in_valid = 1'b0; op_ready = 1'b1;
      end
      step();
    end
    op_ready = 1'b0;
    n_cmp++; if (b_state !== 4'd0 || b_op_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done got=%0d/%b exp=0/0", b_state, b_op_valid); end
  endtask

  task automatic test_little_endian();
    apply_reset();
    op_ready = 1'b1; opcode_in = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = le_bytes[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (l_op_valid !== 1'b1) begin n_fail++; $display("FAIL le_valid got=%b exp=1", l_op_valid); end
    n_cmp++; if (l_op_a !== 32'h3F800000) begin n_fail++; $display("FAIL le_op_a got=%h exp=3f800000", l_op_a); end
    n_cmp++; if (l_op_b !== 32'hC0000000) begin n_fail++; $display("FAIL le_op_b got=%h exp=c0000000", l_op_b); end
    step();
  endtask

  task automatic test_restart();
    apply_reset();
    op_ready = 1'b1; opcode_in = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_byte = 8'hA0 + 8'(i);
      step();
    end
    start = 1'b1; opcode_in = 2'b11; in_valid = 1'b1; in_byte = 8'hEE;
    step();
    start = 1'b0;
    n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL rs_err got=%b exp=1", b_err); end
    n_cmp++; if (b_state !== 4'd1 || b_opcode !== 2'b11) begin n_fail++; $display("FAIL rs_state got=%0d/%b exp=1/11", b_state, b_opcode); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = rs_bytes[i];
      step();
      if (i == 0) begin
        n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL rs_err_pulse got=%b exp=0", b_err); end
      end
      if (i == 3) begin
        n_cmp++; if (b_state !== 4'd2) begin n_fail++; $display("FAIL rs_to_b got=%0d exp=2", b_state); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (b_op_valid !== 1'b1 || b_err !== 1'b0) begin n_fail++; $display("FAIL rs_valid got=%b/%b exp=1/0", b_op_valid, b_err); end
    n_cmp++; if ({b_op_a, b_op_b, b_opcode} !== {32'h12345678, 32'h9ABCDEF0, 2'b11}) begin n_fail++; $display("FAIL rs_data got=%h %h %b exp=12345678 9abcdef0 11", b_op_a, b_op_b, b_opcode); end
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    op_ready = 1'b1; opcode_in = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_byte = 8'h55;
      step();
    end
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      n_cmp++; if (l_state !== 4'd1 || l_err !== 1'b0 || l_op_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait empty%0d got=%0d/%b/%b exp=1/0/0", e, l_state, l_err, l_op_valid); end
    end
    step();
    n_cmp++; if (l_state !== 4'd0 || l_busy !== 1'b0) begin n_fail++; $display("FAIL to_idle got=%0d/%b exp=0/0", l_state, l_busy); end
    n_cmp++; if (l_err !== 1'b1 || l_op_valid !== 1'b0) begin n_fail++; $display("FAIL to_err got=%b/%b exp=1/0", l_err, l_op_valid); end
    step();
    n_cmp++; if (l_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got=%b exp=0", l_err); end
  endtask

  task automatic test_no_timeout();
    int n_err_seen;
    apply_reset();
    opcode_in = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    n_err_seen = 0;
    for (int e = 1; e <= 300; e++) begin
      step();
      if (n_err === 1'b1) n_err_seen++;
      if (e == 255) begin
        n_cmp++; if (b_state !== 4'd1) begin n_fail++; $display("FAIL to255_hold got=%0d exp=1", b_state); end
      end
      if (e == 256) begin
        n_cmp++; if (b_state !== 4'd0 || b_err !== 1'b1) begin n_fail++; $display("FAIL to255_fire got=%0d/%b exp=0/1", b_state, b_err); end
      end
    end
    n_cmp++; if (n_state !== 4'd1 || n_busy !== 1'b1) begin n_fail++; $display("FAIL nt_state got=%0d/%b exp=1/1", n_state, n_busy); end
    n_cmp++; if (n_err_seen !== 0) begin n_fail++; $display("FAIL nt_err got=%0d exp=0", n_err_seen); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    op_ready = 1'b1; opcode_in = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_byte = rs_bytes[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (b_state !== 4'd2) begin n_fail++; $display("FAIL mid_state got=%0d exp=2", b_state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({b_state, b_opcode, b_op_valid, b_busy, b_err} !== 9'b0) begin n_fail++; $display("FAIL mid_reset_flags got=%b exp=0", {b_state, b_opcode, b_op_valid, b_busy, b_err}); end
    n_cmp++; if (b_op_a !== 32'h0 || b_op_b !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ops got=%h/%h exp=0/0", b_op_a, b_op_b); end
    opcode_in = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_byte = basic_bytes[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if ({b_op_valid, b_op_a, b_op_b, b_opcode} !== {1'b1, 32'h3F800000, 32'h40000000, 2'b01}) begin n_fail++; $display("FAIL mid_after got=%b %h %h %b exp=1 3f800000 40000000 01", b_op_valid, b_op_a, b_op_b, b_opcode); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_little_endian();
    test_restart();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_operand_deserializer.md
Name: fp_operand_deserializer

Overview:
- Byte-serial operand front end that sits directly upstream of the FP ALU core.
- Collects two 32-bit IEEE-754 single-precision operands (A, then B) from the 8-bit input bus, one byte per accepted beat, and latches the 2-bit opcode.
- Presents {op_a, op_b, opcode} to the core over a valid/ready handshake.
- Aborts cleanly on a restart request or an input-stall timeout.

Parameters:
- MSB_FIRST, 1, 1 = first byte of each operand is bits [31:24]; 0 = first byte is bits [7:0].
- TIMEOUT, 255, max idle cycles allowed between accepted bytes while loading; 0 disables the timeout.
- TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  operand byte.
- in_valid  in  1  in_byte is valid this cycle.
- opcode_in  in  2  opcode, sampled on an accepted start.
- start  in  1  begin (or restart) a transaction.
- op_a  out  32  assembled operand A.
- op_b  out  32  assembled operand B.
- opcode  out  2  latched opcode.
- op_valid  out  1  operands ready for the core.
- op_ready  in  1  core accepts operands.
- busy  out  1  high in any state other than IDLE.
- state  out  4  {2'b00, fsm}: IDLE=0, LOAD_A=1, LOAD_B=2, ISSUE=3.
- err  out  1  one-cycle pulse on abort (restart or timeout).

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: fsm=IDLE, op_a=0, op_b=0, opcode=0, op_valid=0, busy=0, err=0, byte counter=0, timeout counter=0. Reset mid-transaction discards all partial data.
- IDLE:
  - start=1: latch opcode_in, clear byte counter and timeout counter, go to LOAD_A.
  - in_valid in IDLE, including in the same cycle as start, is ignored.
- LOAD_A / LOAD_B, byte accept: each cycle with in_valid=1 accepts one byte.
  - MSB_FIRST=1: reg <= {reg[23:0], in_byte}.
  - MSB_FIRST=0: reg <= {in_byte, reg[31:8]}.
  - On accept, the 2-bit byte counter increments and the timeout counter clears.
- LOAD_A / LOAD_B, transitions:
  - The 4th accepted byte in LOAD_A moves to LOAD_B with the counter wrapped to 0.
  - The 4th accepted byte in LOAD_B moves to ISSUE.
  - Minimum latency from start to op_valid is 9 cycles: 8 back-to-back bytes, op_valid high on the cycle after the 8th byte.
- Restart: start=1 in LOAD_A or LOAD_B aborts the transaction.
  - err pulses for 1 cycle, opcode is re-latched, counters clear, go to LOAD_A.
  - start wins over a simultaneous in_valid; that byte is discarded.
- Timeout (TIMEOUT>0): in LOAD_A or LOAD_B, the timeout counter increments on every cycle without in_valid.
  - When it would exceed TIMEOUT (TIMEOUT consecutive empty cycles already elapsed), go to IDLE, pulse err, clear counters.
- ISSUE:
  - op_valid=1, with op_a, op_b and opcode held stable.
  - op_valid & op_ready in the same cycle completes the handshake: next cycle is IDLE with op_valid=0.
  - op_ready already high on entry means ISSUE lasts exactly 1 cycle.
  - start and in_valid are ignored in ISSUE; the transaction is committed. No timeout applies in ISSUE.
- op_ready while op_valid=0 has no effect.
- op_a and op_b keep their last values in IDLE; they are not cleared between transactions.
- A start in the cycle IDLE is re-entered from ISSUE is accepted normally.
- err is never asserted at the same time as op_valid.

Test Plan:
- Basic load: start with opcode_in=2'b01, then bytes 3F 80 00 00 40 00 00 00 back-to-back, op_ready=1 -> op_a=0x3F800000, op_b=0x40000000, opcode=01, op_valid high exactly 1 cycle, 9 cycles after start; state sequence 0,1,1,1,1,2,2,2,2,3,0.
- Backpressure and gaps: same bytes with in_valid low 1 cycle between every byte, op_ready low for 5 cycles in ISSUE -> op_valid held 6 cycles, outputs stable throughout; start and in_byte toggled during ISSUE change nothing.
- Little-endian: MSB_FIRST=0, bytes 00 00 80 3F 00 00 00 C0 -> op_a=0x3F800000, op_b=0xC0000000.
- Restart: after 3 bytes of A, start with opcode_in=2'b11 and a simultaneous in_valid -> err pulse, that byte is dropped, the next 8 bytes form a fresh A/B, opcode=11.
- Timeout: TIMEOUT=4, 2 bytes then in_valid low -> err on the 5th empty cycle, state=0, busy=0, op_valid never asserted; start at TIMEOUT=0 with no bytes stays in LOAD_A indefinitely.
- Reset mid-operation: rst=1 in LOAD_B after 2 bytes -> next cycle all outputs at reset values; a following full transaction completes correctly.
